// File: rtl/darkpablo_rr_arbiter_if.sv
// darkpablo_rr_arbiter_if: core-side and memory-side signal bundle of the shared-memory arbiter
interface darkpablo_rr_arbiter_if #(
    parameter int NCORES = 4,
    parameter int AW     = 32,
    parameter int DW     = 32
);
    localparam int GW = NCORES > 1 ? $clog2(NCORES) : 1;
    logic [NCORES*AW-1:0]   DADDR;
    logic [NCORES*DW-1:0]   DATAO;
    logic [NCORES-1:0]      WR;
    logic [NCORES-1:0]      RD;
    logic [NCORES*DW/8-1:0] BE;
    logic [NCORES*DW-1:0]   DATAI;
    logic [NCORES-1:0]      HLT;
    logic [NCORES-1:0]      ERR;
    logic [GW-1:0]          GNT_ID;
    logic [AW-1:0]          PAB_ADDR;
    logic [DW-1:0]          PAB_DATA;
    logic [DW/8-1:0]        PAB_BE;
    logic                   PAB_RD;
    logic                   PAB_WR;
    logic                   PAB_VALID;
    logic                   MEM_READY;
    logic                   MEM_VALID;
    logic [DW-1:0]          MEM_DATA;
    modport slave (
        input  DADDR, DATAO, WR, RD, BE, MEM_READY, MEM_VALID, MEM_DATA,
        output DATAI, HLT, ERR, GNT_ID, PAB_ADDR, PAB_DATA, PAB_BE, PAB_RD, PAB_WR, PAB_VALID
    );
    modport master (
        output DADDR, DATAO, WR, RD, BE, MEM_READY, MEM_VALID, MEM_DATA,
        input  DATAI, HLT, ERR, GNT_ID, PAB_ADDR, PAB_DATA, PAB_BE, PAB_RD, PAB_WR, PAB_VALID
    );
endinterface

// File: rtl/darkpablo_rr_arbiter.sv
// darkpablo_rr_arbiter: round-robin / fixed-priority arbiter of N core ports onto one memory port
module darkpablo_rr_arbiter #(
    parameter int NCORES    = 4,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int PRIO_MODE = 0,
    parameter int TIMEOUT   = 255
) (
    input logic CLK,
    input logic RES,
    darkpablo_rr_arbiter_if.slave bus
);
    localparam int GW = NCORES > 1 ? $clog2(NCORES) : 1;
    localparam int BW = DW / 8;
    localparam int CW = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     data_q, data_d;
    logic [BW-1:0]     be_q, be_d;
    logic              rd_q, rd_d, wr_q, wr_d, valid_q, valid_d;
    logic [GW-1:0]     gnt_q, gnt_d, ptr_q, ptr_d, sel;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NCORES-1:0] rel_q, rel_d, err_q, err_d, seize;
    logic [DW-1:0]     datai_q [NCORES];
    logic [DW-1:0]     datai_d [NCORES];
    logic              done, tmo;

    assign seize         = bus.WR | bus.RD;
    assign bus.HLT       = seize & ~(rel_q & {NCORES{~RES}});
    assign bus.ERR       = err_q;
    assign bus.GNT_ID    = gnt_q;
    assign bus.PAB_ADDR  = addr_q;
    assign bus.PAB_DATA  = data_q;
    assign bus.PAB_BE    = be_q;
    assign bus.PAB_RD    = rd_q;
    assign bus.PAB_WR    = wr_q;
    assign bus.PAB_VALID = valid_q;

    for (genvar i = 0; i < NCORES; i++) begin : g_datai
        assign bus.DATAI[DW*i +: DW] = datai_q[i];
    end

    // Pick the winner: scan from highest to lowest search slot so the first slot wins
    always_comb begin
        sel = '0;
        for (int k = NCORES - 1; k >= 0; k--) begin
            int j;
            j = PRIO_MODE != 0 ? k : (int'(ptr_q) + k) % NCORES;
            if (seize[j]) sel = GW'(j);
        end
    end

    // Next-state logic; completion and timeout share the tail that hands the core back
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        valid_d = valid_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        rel_d   = rel_q;
        err_d   = '0;
        datai_d = datai_q;
        done    = 1'b0;
        tmo     = 1'b0;
        case (state_q)
            IDLE: if (|seize) begin
                gnt_d   = sel;
                addr_d  = bus.DADDR[AW*int'(sel) +: AW];
                data_d  = bus.DATAO[DW*int'(sel) +: DW];
                be_d    = bus.BE[BW*int'(sel) +: BW];
                rd_d    = bus.RD[sel];
                wr_d    = bus.WR[sel];
                valid_d = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: if (bus.MEM_READY) begin
                valid_d = 1'b0;
                cnt_d   = '0;
                done    = bus.MEM_VALID;
                state_d = bus.MEM_VALID ? ISSUE : WAIT;
            end
            WAIT: begin
                done  = bus.MEM_VALID;
                tmo   = !bus.MEM_VALID && TIMEOUT != 0 && cnt_q + CW'(1) == TMO;
                cnt_d = cnt_q + CW'(1);
            end
            default: begin
                rel_d[gnt_q] = 1'b0;
                ptr_d   = PRIO_MODE != 0 ? ptr_q : (int'(gnt_q) == NCORES - 1 ? '0 : gnt_q + GW'(1));
                state_d = IDLE;
            end
        endcase
        if (done || tmo) begin
            if (tmo || rd_q) datai_d[gnt_q] = tmo ? '1 : bus.MEM_DATA;
            err_d[gnt_q] = tmo;
            rel_d[gnt_q] = 1'b1;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            state_d = RELEASE;
        end
    end

    // State and registered outputs
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            valid_q <= 1'b0;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            rel_q   <= '0;
            err_q   <= '0;
            datai_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            be_q    <= be_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            valid_q <= valid_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            rel_q   <= rel_d;
            err_q   <= err_d;
            datai_q <= datai_d;
        end
    end
endmodule
